serial_sub: RTL and testbench

Bit-serial unsigned subtractor for the accumulator datapath: computes `result = ac - memory` with a borrow-out and zero flag over WIDTH cycles, LSB first. It is the SUB-side counterpart of the combinational ACC+MEM adder. It sits beside that adder in the ALU and is driven by the control unit through a start/done handshake. It trades area for latency: one 1-bit full subtractor plus shift registers.

---
 rtl/alu_pkg.sv | 13 +
 rtl/full_subtractor_1b.sv | 14 +
 rtl/serial_sub.sv | 123 ++++++++++++
 tb/tb_serial_sub.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the serial subtractor state encoding.
// Imported by the ALU sub-blocks.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor: d = a - m - bin, with borrow out.
// Purely combinational; the serial subtractor reuses it once per bit-step.
module full_subtractor_1b (
    input  logic a,
    input  logic m,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ m ^ bin;
    assign bout = (~a & m) | (~(a ^ m) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor (result = ac - memory), LSB first, one bit per cycle.
// Results, borrow and zero flag are presented from a separate output register loaded on completion.
module serial_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ac,
    input  logic [WIDTH-1:0] memory,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    sub_state_t       state_r;
    sub_state_t       state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] sh_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             bout_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;

    logic             d_s;
    logic             bo_s;
    logic             accept_s;
    logic             last_step_s;
    logic [WIDTH-1:0] sh_next_s;

    full_subtractor_1b u_fs (
        .a    (a_r[0]),
        .m    (m_r[0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bo_s)
    );

    assign accept_s    = start && (state_r != SHIFT);
    assign last_step_s = (cnt_r == CW'(WIDTH - 1));
    assign sh_next_s   = {d_s, sh_r[WIDTH-1:1]};

    // Next-state logic; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = SHIFT;
                else       state_next_s = IDLE;
            end
            SHIFT: begin
                if (last_step_s) state_next_s = DONE;
                else             state_next_s = SHIFT;
            end
            DONE: begin
                if (start) state_next_s = SHIFT;
                else       state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == SHIFT);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand shift registers, borrow chain, bit counter and the completion output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            m_r      <= '0;
            sh_r     <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            result_r <= '0;
            bout_r   <= 1'b0;
            zero_r   <= 1'b1;
        end else if (accept_s) begin
            a_r      <= ac;
            m_r      <= memory;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
        end else if (state_r == SHIFT) begin
            a_r      <= a_r >> 1;
            m_r      <= m_r >> 1;
            sh_r     <= sh_next_s;
            borrow_r <= bo_s;
            cnt_r    <= cnt_r + CW'(1);
            // Only the completed difference ever reaches the visible outputs.
            if (last_step_s) begin
                result_r <= sh_next_s;
                bout_r   <= bo_s;
                zero_r   <= (sh_next_s == '0);
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign bout   = bout_r;
    assign zero   = zero_r;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vector table plus hand-written
// back-to-back, mid-operation restart, reset-abort and random sweep sequences.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] ac;
    logic [7:0] memory;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       bout;
    logic       zero;

    int checks;
    int failures;
    int cyc;
    logic [7:0] exp_last;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] m;
        logic [7:0] r;
        logic       b;
        logic       z;
    } vec_t;

    vec_t vecs [9];

    serial_sub #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ac     (ac),
        .memory (memory),
        .busy   (busy),
        .done   (done),
        .result (result),
        .bout   (bout),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait for done. b2b: drive start in the current (DONE) cycle.
    // inj: bit-step index at which a stray start with other operands is pulsed (-1 = none).
    task automatic run_op(input logic [7:0] a, input logic [7:0] m, input bit b2b, input int inj,
                          input logic [7:0] hold_val,
                          output logic [7:0] r, output logic b, output logic z,
                          output int lat, output int busy_cnt, output int hold_err,
                          output int done_cyc, output bit found);
        if (!b2b) @(negedge clk);
        ac = a; memory = m; start = 1'b1;
        @(posedge clk);
        lat = -1; busy_cnt = 0; hold_err = 0; found = 1'b0; done_cyc = 0;
        r = 8'h00; b = 1'b0; z = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == inj) begin start = 1'b1; ac = 8'h11; memory = 8'h22; end
            if (i == inj + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i; found = 1'b1; done_cyc = cyc;
                r = result; b = bout; z = zero;
                break;
            end
            if (result !== hold_val) hold_err++;
        end
    endtask

    logic [7:0] r;
    logic       b, z;
    int         lat, busy_cnt, hold_err, dc1, dc2, done_seen;
    bit         found;
    logic [8:0] exp9;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; ac = 8'h00; memory = 8'h00;
        exp_last = 8'h00;

        vecs[0] = '{a: 8'h95, m: 8'h8A, r: 8'h0B, b: 1'b0, z: 1'b0};
        vecs[1] = '{a: 8'h49, m: 8'h1A, r: 8'h2F, b: 1'b0, z: 1'b0};
        vecs[2] = '{a: 8'hAA, m: 8'hB5, r: 8'hF5, b: 1'b1, z: 1'b0};
        vecs[3] = '{a: 8'h3C, m: 8'h3C, r: 8'h00, b: 1'b0, z: 1'b1};
        vecs[4] = '{a: 8'h00, m: 8'h01, r: 8'hFF, b: 1'b1, z: 1'b0};
        vecs[5] = '{a: 8'hFF, m: 8'h00, r: 8'hFF, b: 1'b0, z: 1'b0};
        vecs[6] = '{a: 8'h00, m: 8'h00, r: 8'h00, b: 1'b0, z: 1'b1};
        vecs[7] = '{a: 8'h80, m: 8'h7F, r: 8'h01, b: 1'b0, z: 1'b0};
        vecs[8] = '{a: 8'h7F, m: 8'h80, r: 8'hFF, b: 1'b1, z: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_bout",   {31'd0, bout},   32'd0);
        chk("rst_zero",   {31'd0, zero},   32'd1);

        // Directed table
        for (int k = 0; k < 9; k++) begin
            run_op(vecs[k].a, vecs[k].m, 1'b0, -1, exp_last, r, b, z, lat, busy_cnt, hold_err, dc1, found);
            chk("vec_found",  {31'd0, found}, 32'd1);
            chk("vec_result", {24'd0, r},     {24'd0, vecs[k].r});
            chk("vec_bout",   {31'd0, b},     {31'd0, vecs[k].b});
            chk("vec_zero",   {31'd0, z},     {31'd0, vecs[k].z});
            chk("vec_latency", lat, 32'd8);
            chk("vec_busy_cycles", busy_cnt, 32'd8);
            chk("vec_hold", hold_err, 32'd0);
            exp_last = vecs[k].r;
        end

        // Back-to-back: second start in the DONE cycle of the first
        run_op(8'h49, 8'h1A, 1'b0, -1, exp_last, r, b, z, lat, busy_cnt, hold_err, dc1, found);
        chk("b2b1_result", {24'd0, r}, 32'h2F);
        chk("b2b1_bout",   {31'd0, b}, 32'd0);
        chk("b2b1_busy_in_done", {31'd0, busy}, 32'd0);
        exp_last = 8'h2F;
        run_op(8'hAA, 8'hB5, 1'b1, -1, exp_last, r, b, z, lat, busy_cnt, hold_err, dc2, found);
        chk("b2b2_found",  {31'd0, found}, 32'd1);
        chk("b2b2_result", {24'd0, r}, 32'hF5);
        chk("b2b2_bout",   {31'd0, b}, 32'd1);
        chk("b2b_done_gap", dc2 - dc1, 32'd9);
        chk("b2b2_busy_cycles", busy_cnt, 32'd8);
        chk("b2b2_hold", hold_err, 32'd0);
        exp_last = 8'hF5;

        // Stray start mid-SHIFT is ignored
        run_op(8'h95, 8'h8A, 1'b0, 3, exp_last, r, b, z, lat, busy_cnt, hold_err, dc1, found);
        chk("midstart_result", {24'd0, r}, 32'h0B);
        chk("midstart_bout",   {31'd0, b}, 32'd0);
        chk("midstart_latency", lat, 32'd8);
        chk("midstart_hold", hold_err, 32'd0);
        exp_last = 8'h0B;
        @(negedge clk);
        chk("midstart_no_restart", {31'd0, busy}, 32'd0);

        // Reset at bit-step 4 aborts the operation
        @(negedge clk);
        ac = 8'h95; memory = 8'h8A; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   {31'd0, busy},   32'd0);
        chk("abort_done",   {31'd0, done},   32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_zero",   {31'd0, zero},   32'd1);
        chk("abort_bout",   {31'd0, bout},   32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 32'd0);
        exp_last = 8'h00;
        run_op(8'h95, 8'h8A, 1'b0, -1, exp_last, r, b, z, lat, busy_cnt, hold_err, dc1, found);
        chk("post_abort_result", {24'd0, r}, 32'h0B);
        chk("post_abort_latency", lat, 32'd8);
        exp_last = 8'h0B;

        // Random sweep
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra, rm;
            ra = 8'($urandom_range(0, 255));
            rm = 8'($urandom_range(0, 255));
            exp9 = {1'b0, ra} - {1'b0, rm};
            run_op(ra, rm, 1'b0, -1, exp_last, r, b, z, lat, busy_cnt, hold_err, dc1, found);
            chk("rand_borrow_result", {23'd0, b, r}, {23'd0, exp9});
            chk("rand_zero", {31'd0, z}, {31'd0, (exp9[7:0] == 8'h00)});
            chk("rand_latency", lat, 32'd8);
            exp_last = exp9[7:0];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
